// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_STOP2_EN to append a second stop bit to every frame.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

`ifdef UART_TX_STOP2_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`endif

  state_t state, state_next;
  logic   par_bit;
  logic   par_en_q;
  logic   accept;

  // The shifter loads P_DATA on this same edge, so parity is captured here too.
  assign accept = (state == IDLE) && DATA_VALID;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        par_bit  <= (^P_DATA) ^ PAR_TYP;
        par_en_q <= PAR_EN;
      end
    end
  end

  always_comb begin
    state_next = state;
    TX_OUT     = 1'b1;
    busy       = 1'b0;
    ser_en     = 1'b0;
    case (state)
      IDLE: begin
        if (DATA_VALID) state_next = START;
      end
      START: begin
        TX_OUT     = 1'b0;
        busy       = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
        if (ser_done) state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        TX_OUT     = par_bit;
        busy       = 1'b1;
        state_next = STOP;
      end
      STOP: begin
        busy = 1'b1;
`ifdef UART_TX_STOP2_EN
        state_next = STOP2;
`else
        state_next = IDLE;
`endif
      end
`ifdef UART_TX_STOP2_EN
      STOP2: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a behavioural shifter and a frame-level reference model.
// Honours UART_TX_STOP2_EN for the expected stop-bit count.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DATA_VALID;
  logic [7:0] P_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;

  logic [7:0] sh_reg;
  logic [2:0] sh_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  // Stand-in for the existing parallel-to-serial shifter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_reg <= 8'h00;
      sh_cnt <= 3'd0;
    end else if (DATA_VALID && !busy) begin
      sh_reg <= P_DATA;
      sh_cnt <= 3'd0;
    end else if (ser_en) begin
      sh_reg <= {1'b0, sh_reg[7:1]};
      sh_cnt <= sh_cnt + 3'd1;
    end
  end

  assign ser_data = sh_reg[0];
  assign ser_done = (sh_cnt == 3'd7);

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge CLK);
    chk({name, " idle tx"}, TX_OUT, 1'b1);
    chk({name, " idle busy"}, busy, 1'b0);
    chk({name, " idle ser_en"}, ser_en, 1'b0);
  endtask

  // Checks one whole frame, starting with the first sample after the accept edge.
  task automatic check_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input bit noise, input logic dv_after, input string name);
    logic bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (pen) bits.push_back(1'(($countones(d) % 2) ^ int'(ptyp)));
    bits.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
    bits.push_back(1'b1);
`endif
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx[%0d]", name, i), TX_OUT, bits[i]);
      chk($sformatf("%s busy[%0d]", name, i), busy, 1'b1);
      chk($sformatf("%s ser_en[%0d]", name, i), ser_en, 1'((i >= 1) && (i <= 8)));
      if (i == bits.size() - 1) begin
        DATA_VALID = dv_after;
      end else if (noise) begin
        DATA_VALID = 1'($urandom_range(0, 1));
        P_DATA     = 8'($urandom_range(0, 255));
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input string name);
    @(negedge CLK);
    DATA_VALID = 1'b1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    check_frame(d, pen, ptyp, 1'b1, 1'b0, name);
    check_idle(name);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic       rt;

    RST        = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset ser_en", ser_en, 1'b0);
    RST = 1'b0;
    check_idle("post_reset0");
    check_idle("post_reset1");

    send(8'hA5, 1'b1, 1'b0, "a5_even");
    send(8'h07, 1'b1, 1'b1, "07_odd");
    send(8'h07, 1'b1, 1'b0, "07_even");
    send(8'h3C, 1'b0, 1'b0, "3c_nopar");
    send(8'hFF, 1'b0, 1'b0, "ff_nopar");
    send(8'h00, 1'b1, 1'b1, "00_odd");

    // DATA_VALID held: second frame follows after exactly one idle cycle.
    @(negedge CLK);
    DATA_VALID = 1'b1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    @(posedge CLK);
    #1 P_DATA = 8'hAA;
    check_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, "b2b_first");
    check_idle("b2b_gap");
    check_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_second");
    check_idle("b2b_end");

    // Reset asserted during the 4th data bit (bit 3 of 0x96 is 0).
    @(negedge CLK);
    DATA_VALID = 1'b1;
    P_DATA     = 8'h96;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("mid tx bit3", TX_OUT, 1'b0);
    chk("mid busy", busy, 1'b1);
    RST = 1'b1;
    #1;
    chk("rst_mid tx", TX_OUT, 1'b1);
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid ser_en", ser_en, 1'b0);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_hold tx", TX_OUT, 1'b1);
      chk("rst_hold busy", busy, 1'b0);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) check_idle($sformatf("rst_release%0d", i));
    send(8'h96, 1'b1, 1'b0, "after_reset");

    for (int n = 0; n < 20; n++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      send(rd, rp, rt, $sformatf("rand%0d_%02h_p%0b%0b", n, rd, rp, rt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
